// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through fetch, decode/execute and
// memory/writeback with start/done handshakes, commits PC on retire, halts, and traps hung stages.
module core_sequencer #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             fetch_start,
   input  logic             fetch_done,
   output logic             de_start,
   input  logic             de_done,
   output logic             mw_start,
   input  logic             mw_done,
   input  logic             halt_req,
   output logic             pc_we,
   output logic [CNT_W-1:0] retire_count,
   output logic [2:0]       state,
   output logic             halted,
   output logic             error
);

   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_DE   = 3'd2,
      S_MW   = 3'd3,
      S_HALT = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   retire_q, retire_d;
   logic               fetch_start_q, fetch_start_d;
   logic               de_start_q, de_start_d;
   logic               mw_start_q, mw_start_d;
   logic               pc_we_q, pc_we_d;
   logic               halted_q, halted_d;
   logic               error_q, error_d;
   logic               first_cycle, in_stage, done_sel, done_acc, timeout_hit;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      retire_d      = retire_q;
      halted_d      = halted_q;
      error_d       = error_q;
      pc_we_d       = 1'b0;
      done_sel      = 1'b0;

      // The start-pulse cycle of a stage never accepts its done, giving a 2-cycle minimum occupancy.
      first_cycle = fetch_start_q | de_start_q | mw_start_q;
      in_stage    = (state_q == S_IF) || (state_q == S_DE) || (state_q == S_MW);
      case (state_q)
         S_IF:    done_sel = fetch_done;
         S_DE:    done_sel = de_done;
         S_MW:    done_sel = mw_done;
         default: done_sel = 1'b0;
      endcase
      done_acc    = in_stage && !first_cycle && done_sel;
      timeout_hit = (TIMEOUT != 0) && in_stage && !done_acc && (wait_q == WAIT_W'(TIMEOUT));

      case (state_q)
         S_IDLE: state_d = S_IF;
         S_IF: begin
            if (done_acc)         state_d = S_DE;
            else if (timeout_hit) state_d = S_ERR;
         end
         S_DE: begin
            if (done_acc)         state_d = S_MW;
            else if (timeout_hit) state_d = S_ERR;
         end
         S_MW: begin
            if (done_acc) begin
               retire_d = retire_q + 1'b1;
               if (halt_req) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_IF;
                  pc_we_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d = S_ERR;
            end
         end
         default: state_d = state_q;
      endcase

      if (timeout_hit) error_d = 1'b1;

      fetch_start_d = (state_d == S_IF) && (state_q != S_IF);
      de_start_d    = (state_d == S_DE) && (state_q != S_DE);
      mw_start_d    = (state_d == S_MW) && (state_q != S_MW);

      // Every stage entry restarts the watchdog; a timeout always leaves the stage, so no overflow.
      if (state_d != state_q)               wait_d = '0;
      else if (in_stage && (TIMEOUT != 0))  wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wait_q        <= '0;
         retire_q      <= '0;
         fetch_start_q <= 1'b0;
         de_start_q    <= 1'b0;
         mw_start_q    <= 1'b0;
         pc_we_q       <= 1'b0;
         halted_q      <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         retire_q      <= retire_d;
         fetch_start_q <= fetch_start_d;
         de_start_q    <= de_start_d;
         mw_start_q    <= mw_start_d;
         pc_we_q       <= pc_we_d;
         halted_q      <= halted_d;
         error_q       <= error_d;
      end
   end

   assign fetch_start  = fetch_start_q;
   assign de_start     = de_start_q;
   assign mw_start     = mw_start_q;
   assign pc_we        = pc_we_q;
   assign retire_count = retire_q;
   assign state        = state_q;
   assign halted       = halted_q;
   assign error        = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: vector table, randomized timeline model, halt, reset, watchdog and wrap cases.
module tb_core_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Instance A: default parameters
   logic        a_rst = 1'b1, a_fd = 1'b0, a_dd = 1'b0, a_md = 1'b0, a_hr = 1'b0;
   logic        a_fs, a_ds, a_ms, a_pc, a_hl, a_er;
   logic [31:0] a_rc;
   logic [2:0]  a_st;

   // Instance B: short watchdog, narrow counter
   logic        b_rst = 1'b1, b_fd = 1'b0, b_dd = 1'b0, b_md = 1'b0, b_hr = 1'b0;
   logic        b_fs, b_ds, b_ms, b_pc, b_hl, b_er;
   logic [3:0]  b_rc;
   logic [2:0]  b_st;

   core_sequencer u_dut_a (
      .clk(clk), .rst(a_rst), .fetch_start(a_fs), .fetch_done(a_fd), .de_start(a_ds),
      .de_done(a_dd), .mw_start(a_ms), .mw_done(a_md), .halt_req(a_hr), .pc_we(a_pc),
      .retire_count(a_rc), .state(a_st), .halted(a_hl), .error(a_er)
   );

   core_sequencer #(.TIMEOUT(8), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(b_rst), .fetch_start(b_fs), .fetch_done(b_fd), .de_start(b_ds),
      .de_done(b_dd), .mw_start(b_ms), .mw_done(b_md), .halt_req(b_hr), .pc_we(b_pc),
      .retire_count(b_rc), .state(b_st), .halted(b_hl), .error(b_er)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Simple responder state: done raised dly cycles after each observed start pulse
   int a_n, a_sf, a_sd, a_sm, a_dly;
   int b_n, b_sf, b_sd, b_sm, b_dly;
   logic b_hold_f = 1'b0, b_block_d = 1'b0;

   task automatic reset_a();
      a_rst = 1'b1; a_fd = 0; a_dd = 0; a_md = 0; a_hr = 0;
      a_sf = -1; a_sd = -1; a_sm = -1;
      tick(); tick();
      a_rst = 1'b0;
      a_n = 0;
   endtask

   task automatic a_step();
      tick();
      a_n++;
      if (a_fs) a_sf = a_n + a_dly;
      if (a_ds) a_sd = a_n + a_dly;
      if (a_ms) a_sm = a_n + a_dly;
      a_fd = (a_n == a_sf);
      a_dd = (a_n == a_sd);
      a_md = (a_n == a_sm);
   endtask

   task automatic reset_b();
      b_rst = 1'b1; b_fd = 0; b_dd = 0; b_md = 0; b_hr = 0;
      b_sf = -1; b_sd = -1; b_sm = -1;
      b_hold_f = 0; b_block_d = 0;
      tick(); tick();
      b_rst = 1'b0;
      b_n = 0;
   endtask

   task automatic b_step();
      tick();
      b_n++;
      if (b_fs) b_sf = b_n + b_dly;
      if (b_ds) b_sd = b_n + b_dly;
      if (b_ms) b_sm = b_n + b_dly;
      b_fd = b_hold_f ? 1'b1 : (b_n == b_sf);
      b_dd = !b_block_d && (b_n == b_sd);
      b_md = (b_n == b_sm);
   endtask

   typedef struct {
      logic       rst, fd, dd, md, hr;
      logic       fs, ds, ms, pc, hl;
      logic [2:0] st;
      int         rc;
   } vec_t;

   function automatic vec_t mk(input logic rst, fd, dd, md, hr, fs, ds, ms, pc, hl,
                               input logic [2:0] st, input int rc);
      vec_t v;
      v.rst = rst; v.fd = fd; v.dd = dd; v.md = md; v.hr = hr;
      v.fs = fs; v.ds = ds; v.ms = ms; v.pc = pc; v.hl = hl; v.st = st; v.rc = rc;
      return v;
   endfunction

   task automatic run_table();
      vec_t tbl[17];
      //          rst fd dd md hr  fs ds ms pc hl st rc
      tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
      tbl[3]  = mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 2, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0);
      tbl[5]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 3, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 1, 1);
      tbl[8]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
      tbl[9]  = mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 2, 1);
      tbl[10] = mk(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 2, 1);
      tbl[11] = mk(0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 3, 1);
      tbl[12] = mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3, 1);
      tbl[13] = mk(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 4, 2);
      tbl[14] = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 4, 2);
      tbl[15] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0);
      for (int r = 0; r < 17; r++) begin
         a_rst = tbl[r].rst; a_fd = tbl[r].fd; a_dd = tbl[r].dd; a_md = tbl[r].md; a_hr = tbl[r].hr;
         tick();
         chk($sformatf("tbl%0d_state", r), a_st, tbl[r].st);
         chk($sformatf("tbl%0d_fs", r), a_fs, tbl[r].fs);
         chk($sformatf("tbl%0d_ds", r), a_ds, tbl[r].ds);
         chk($sformatf("tbl%0d_ms", r), a_ms, tbl[r].ms);
         chk($sformatf("tbl%0d_pcwe", r), a_pc, tbl[r].pc);
         chk($sformatf("tbl%0d_halted", r), a_hl, tbl[r].hl);
         chk($sformatf("tbl%0d_rc", r), a_rc, tbl[r].rc);
         chk($sformatf("tbl%0d_err", r), a_er, 0);
      end
   endtask

   // Timeline model: a stage whose done arrives d cycles after its start occupies d+1 cycles.
   task automatic run_random();
      int fdl[11], ddl[11], mdl[11];
      bit efs[2048], eds[2048], ems[2048], epc[2048];
      int t, last, nfs, nds, nms, npc, i, sf, sd, sm;
      foreach (efs[k]) begin efs[k] = 0; eds[k] = 0; ems[k] = 0; epc[k] = 0; end
      for (int k = 0; k < 11; k++) begin
         fdl[k] = $urandom_range(1, 20);
         ddl[k] = $urandom_range(1, 20);
         mdl[k] = $urandom_range(1, 20);
      end
      t = 1;
      for (int k = 0; k < 10; k++) begin
         efs[t] = 1;
         if (k > 0) epc[t] = 1;
         t = t + fdl[k] + 1; eds[t] = 1;
         t = t + ddl[k] + 1; ems[t] = 1;
         t = t + mdl[k] + 1;
      end
      efs[t] = 1; epc[t] = 1;
      last = t;
      reset_a();
      nfs = 0; nds = 0; nms = 0; npc = 0; i = 0; sf = -1; sd = -1; sm = -1;
      for (int n = 1; n <= last; n++) begin
         tick();
         chk($sformatf("rnd_fs@%0d", n), a_fs, efs[n]);
         chk($sformatf("rnd_ds@%0d", n), a_ds, eds[n]);
         chk($sformatf("rnd_ms@%0d", n), a_ms, ems[n]);
         chk($sformatf("rnd_pcwe@%0d", n), a_pc, epc[n]);
         chk($sformatf("rnd_err@%0d", n), a_er, 0);
         if (a_fs) begin i = (nfs < 11) ? nfs : 10; nfs++; sf = n + fdl[i]; end
         if (a_ds) begin nds++; sd = n + ddl[i]; end
         if (a_ms) begin nms++; sm = n + mdl[i]; end
         if (a_pc) npc++;
         a_fd = (n == sf);
         a_dd = (n == sd);
         a_md = (n == sm);
         a_hr = a_md ? 1'b0 : 1'($urandom_range(0, 1));
      end
      chk("rnd_retire_count", a_rc, 10);
      chk("rnd_pcwe_pulses", npc, 10);
      chk("rnd_fs_pulses", nfs, 11);
      chk("rnd_ds_pulses", nds, 10);
      chk("rnd_ms_pulses", nms, 10);
      a_fd = 0; a_dd = 0; a_md = 0; a_hr = 0;
   endtask

   task automatic run_halt();
      int nmd, npc, pulses;
      bit reached;
      reset_a();
      a_dly = 2; nmd = 0; npc = 0; reached = 0;
      for (int k = 0; k < 200 && !reached; k++) begin
         a_step();
         if (a_pc) npc++;
         if (a_st == 3'd4) reached = 1;
         else begin
            a_hr = a_md ? (nmd == 2) : 1'b1;
            if (a_md) nmd++;
         end
      end
      chk("halt_reached", reached, 1);
      chk("halt_retire_count", a_rc, 3);
      chk("halt_state", a_st, 4);
      chk("halt_halted", a_hl, 1);
      chk("halt_pcwe_before", npc, 2);
      pulses = 0;
      for (int k = 0; k < 50; k++) begin
         a_step();
         a_fd = 1; a_dd = 1; a_md = 1; a_hr = 1'($urandom_range(0, 1));
         pulses += int'(a_fs) + int'(a_ds) + int'(a_ms) + int'(a_pc);
      end
      chk("halt_no_pulses", pulses, 0);
      chk("halt_rc_frozen", a_rc, 3);
      chk("halt_state_hold", a_st, 4);
      a_fd = 0; a_dd = 0; a_md = 0; a_hr = 0;
   endtask

   task automatic run_rst_mid();
      bit reached;
      reset_a();
      a_dly = 1; a_hr = 0; reached = 0;
      for (int k = 0; k < 100 && !reached; k++) begin
         a_step();
         if (a_st == 3'd3 && a_rc == 1) reached = 1;
      end
      chk("rstmid_reached_mw", reached, 1);
      a_rst = 1; a_md = 1; a_fd = 0; a_dd = 0;
      tick();
      chk("rstmid_state", a_st, 0);
      chk("rstmid_rc", a_rc, 0);
      chk("rstmid_pcwe", a_pc, 0);
      chk("rstmid_fs", a_fs, 0);
      a_rst = 0; a_md = 0;
      tick();
      chk("rstmid_state_next", a_st, 1);
      chk("rstmid_fs_next", a_fs, 1);
      chk("rstmid_pcwe_next", a_pc, 0);
   endtask

   task automatic b_reach_de(input string tag);
      bit seen;
      seen = 0;
      b_dly = 1;
      for (int k = 0; k < 20 && !seen; k++) begin
         b_step();
         if (b_ds) seen = 1;
      end
      chk({tag, "_de_start_seen"}, seen, 1);
      b_block_d = 1;
      b_dd = 0;
   endtask

   task automatic run_timeout();
      reset_b();
      b_reach_de("wd");
      for (int k = 1; k <= 12; k++) begin
         b_step();
         chk($sformatf("wd_state+%0d", k), b_st, (k < 9) ? 2 : 5);
         chk($sformatf("wd_error+%0d", k), b_er, (k >= 9) ? 1 : 0);
         if (k >= 9) chk($sformatf("wd_pulses+%0d", k), b_fs | b_ds | b_ms | b_pc, 0);
      end
      reset_b();
      b_reach_de("wdwin");
      for (int k = 1; k <= 8; k++) begin
         b_step();
         chk($sformatf("wdwin_state+%0d", k), b_st, 2);
         if (k == 8) b_dd = 1;
      end
      b_step();
      chk("wdwin_state_mw", b_st, 3);
      chk("wdwin_ms", b_ms, 1);
      chk("wdwin_error", b_er, 0);
   endtask

   task automatic run_wrap();
      int npc, last_fs;
      reset_b();
      b_dly = 1; b_hold_f = 1; b_block_d = 0; b_fd = 1;
      npc = 0; last_fs = 0;
      for (int k = 0; k < 400 && npc < 17; k++) begin
         b_step();
         if (b_fs) last_fs = b_n;
         if (b_ds) chk("wrap_if_len", b_n - last_fs, 2);
         if (b_pc) begin
            npc++;
            chk($sformatf("wrap_rc_%0d", npc), b_rc, npc % 16);
         end
      end
      chk("wrap_retires", npc, 17);
      chk("wrap_rc_final", b_rc, 1);
      chk("wrap_error", b_er, 0);
      b_hold_f = 0;
   endtask

   initial begin
      a_dly = 1; b_dly = 1;
      run_table();
      run_random();
      run_halt();
      run_rst_mid();
      run_timeout();
      run_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout: got stuck, expected completion");
      $fatal(1, "bench time limit exceeded");
   end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the non-pipelined core.
- Steps each instruction through three stages in order: fetch, decode_execute, memory_writeback.
- Issues a one-cycle start pulse to each stage and waits for that stage's done.
- Commits the PC on retire, counts retired instructions, handles halt requests, and flags stages that hang via a watchdog.

Parameters:
- TIMEOUT, 255: max cycles to wait for a stage done after its start pulse; 0 disables the watchdog.
- CNT_W, 32: width of retire_count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- fetch_start  output  1  one-cycle pulse: begin instruction fetch.
- fetch_done  input  1  fetch stage finished; instruction valid.
- de_start  output  1  one-cycle pulse: begin decode/execute.
- de_done  input  1  decode/execute finished; alu_out/rd_num valid.
- mw_start  output  1  one-cycle pulse: begin memory/writeback.
- mw_done  input  1  memory/writeback finished; regfile write performed.
- halt_req  input  1  current instruction is ecall/ebreak; sampled with mw_done only.
- pc_we  output  1  one-cycle pulse: commit next PC.
- retire_count  output  CNT_W  retired-instruction counter.
- state  output  3  current state encoding, for debug.
- halted  output  1  sticky: core halted.
- error  output  1  sticky: watchdog expired.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- State encoding: IDLE=0, IF=1, DE=2, MW=3, HALT=4, ERR=5. All outputs are registered.
- Reset values: state=IDLE; all start pulses, pc_we, halted and error = 0; retire_count=0; wait counter=0.
- IDLE: held for exactly one cycle after rst deasserts, then IF.
- Entering IF/DE/MW: the matching *_start is 1 in the first cycle of the state only. The wait counter clears to 0.
- Done sampling: the done input is ignored in the start-pulse cycle and sampled from the following cycle onward. Minimum stage occupancy is 2 cycles. A done that is already high in the start cycle is not accepted until the next cycle.
- Done inputs of stages that are not the current state are ignored.
- IF: fetch_done=1 moves to DE next cycle.
- DE: de_done=1 moves to MW next cycle.
- MW: mw_done=1 retires the instruction. In the next cycle retire_count increments by 1, wrapping modulo 2^CNT_W.
  - halt_req=0: next state IF, with pc_we=1 and fetch_start=1 in the same cycle.
  - halt_req=1: next state HALT, pc_we stays 0, halted=1.
- Minimum instruction latency: 6 cycles, start of IF to start of next IF.
- HALT and ERR: terminal until rst. No start pulses, no pc_we, retire_count frozen.
- Watchdog (TIMEOUT>0):
  - The wait counter increments each cycle in IF/DE/MW that has no accepted done.
  - When the counter equals TIMEOUT with no done, the next state is ERR and error=1.
  - A done arriving in the same cycle the counter reaches TIMEOUT wins: normal transition, no error.
- rst mid-stage: returns to IDLE next cycle and clears counters and sticky flags. No pc_we is issued, and the in-flight instruction is discarded.

Test Plan:
- Reset release, then each stage's done arrives 1 cycle after its start -> fetch_start at cycle 1, de_start at 3, mw_start at 5, pc_we + fetch_start at 7, retire_count=1.
- 10 instructions with randomized done delays of 1-20 cycles -> exactly one pulse of each start per instruction in IF/DE/MW order; 10 pc_we pulses; retire_count=10; error=0.
- mw_done=1 with halt_req=1 on the 3rd instruction -> retire_count=3, state=4, halted=1, no further pc_we or start pulses over 50 cycles. halt_req=1 asserted outside mw_done is ignored.
- TIMEOUT=8, de_done withheld -> state=5, error=1 exactly 9 cycles after de_start. Separate run: de_done on the counter==8 cycle -> MW, error=0.
- rst asserted for 1 cycle while in MW -> state=0 next cycle, retire_count=0, no pc_we; fetch_start follows 1 cycle later.
- CNT_W=4, 17 retires -> retire_count wraps to 1. fetch_done held high continuously -> IF still lasts 2 cycles per instruction.
